// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared encodings for the data memory arbiter
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    localparam int RW_READ  = 1;
    localparam int RW_WRITE = 0;

    localparam logic PORT_LOAD  = 1'b0;
    localparam logic PORT_STORE = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_pick.sv
// rtl/data_mem_arbiter_pick.sv - two-requester picker, round-robin under DATA_MEM_ARB_RR_EN
// ptr holds the last winner; with round-robin the other port wins a tie.
module data_mem_arb_pick
    import data_mem_arbiter_pkg::*;
(
    input  logic [1:0] eligible,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       owner
);

`ifdef DATA_MEM_ARB_RR_EN
    always_comb begin
        owner = eligible[PORT_STORE];
        if (&eligible) begin
            owner = ~ptr;
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        owner = eligible[PORT_STORE];
    end
`endif

    always_comb begin
        grant = 2'b00;
        if (eligible[owner]) begin
            grant = owner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - load/store-commit arbiter for the single-ported data memory
// Optional DATA_MEM_ARB_RR_EN: round-robin between ports instead of store-first priority.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [MASK_W-1:0] p0_mask,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [MASK_W-1:0] p1_mask,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              mem_free,
    input  logic              mem_read_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        mem_rw_flag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_mask,
    output logic              busy
);

    arb_state_t state, state_nxt;
    logic       hold_we;
    logic       owner;
    logic       ptr;
    logic       pick_owner;
    logic [1:0] eligible;
    logic [1:0] grant;
    logic       load;
    logic       complete;

    // A port still showing req in its ack cycle must not be granted again.
    assign eligible = {p1_req & ~p1_ack, p0_req & ~p0_ack};

    data_mem_arb_pick u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant),
        .owner    (pick_owner)
    );

`ifdef DATA_MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PORT_LOAD;
        end else if (load) begin
            ptr <= pick_owner;
        end
    end
`else
    assign ptr = PORT_LOAD;
`endif

    // The ack cycle is a mandatory bubble: no grant while any ack is high.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        complete  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_free && (|grant) && !(p0_ack || p1_ack)) begin
                    load      = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (mem_free && (hold_we || mem_read_valid)) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rw_flag = 2'b00;
        if (state == ST_ISSUE) begin
            mem_rw_flag[RW_READ]  = ~hold_we;
            mem_rw_flag[RW_WRITE] = hold_we;
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= PORT_LOAD;
            hold_we   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_mask  <= '0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            state    <= state_nxt;
            p0_ack   <= complete && (owner == PORT_LOAD);
            p1_ack   <= complete && (owner == PORT_STORE);
            p0_rdata <= (complete && !hold_we && owner == PORT_LOAD)  ? mem_rdata : '0;
            p1_rdata <= (complete && !hold_we && owner == PORT_STORE) ? mem_rdata : '0;
            // The memory samples addr/data/mask at completion, so they are held until then.
            if (load) begin
                owner     <= pick_owner;
                hold_we   <= pick_owner ? p1_we    : p0_we;
                mem_addr  <= pick_owner ? p1_addr  : p0_addr;
                mem_wdata <= pick_owner ? p1_wdata : p0_wdata;
                mem_mask  <= pick_owner ? p1_mask  : p0_mask;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter with a 2-cycle memory model
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]  p0_mask, p1_mask;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_free, mem_read_valid;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rw_flag;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic        busy;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_mask(p0_mask), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_mask(p1_mask), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_free(mem_free), .mem_read_valid(mem_read_valid), .mem_rdata(mem_rdata),
        .mem_rw_flag(mem_rw_flag), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .busy(busy)
    );

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] rdata;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] tb_mem[16];
    logic [31:0] ref_mem[16];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          issue_cyc = 0;
    int          req_cyc = 0;
    int          last_gap = 0;
    bit          issue_seen = 0;
    logic [1:0]  flag_prev = 2'b00;
    logic [31:0] last_rdata = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: busy for one cycle after the issue, then free again with a read-data pulse.
    logic m_busy, m_rd;
    always @(posedge clk) begin
        if (rst) begin
            mem_free       <= 1'b1;
            mem_read_valid <= 1'b0;
            mem_rdata      <= '0;
            m_busy         <= 1'b0;
            m_rd           <= 1'b0;
            for (int i = 0; i < 16; i++) tb_mem[i] <= 32'h1000_0000 + 32'(i);
            tb_mem[2] <= 32'hAABB_CCDD;
            tb_mem[4] <= 32'hDEAD_BEEF;
        end else begin
            mem_read_valid <= 1'b0;
            mem_rdata      <= 32'hA5A5_A5A5;
            if (m_busy) begin
                m_busy   <= 1'b0;
                mem_free <= 1'b1;
                if (m_rd) begin
                    mem_read_valid <= 1'b1;
                    mem_rdata      <= tb_mem[mem_addr[5:2]];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (mem_mask[b]) tb_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else if (mem_rw_flag != 2'b00) begin
                m_busy   <= 1'b1;
                mem_free <= 1'b0;
                m_rd     <= mem_rw_flag[1];
            end
        end
    end

    task automatic init_ref();
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
        ref_mem[2] = 32'hAABB_CCDD;
        ref_mem[4] = 32'hDEAD_BEEF;
    endtask

    task automatic push(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask);
        sb_t e;
        e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.mask = mask; e.rdata = '0;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (mask[b]) ref_mem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            e.rdata = ref_mem[addr[5:2]];
        end
        sb.push_back(e);
    endtask

    task automatic drive(input int port, input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
        if (port == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_mask = mask;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_mask = mask;
        end
    endtask

    task automatic wait_ack(input int port);
        bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((port == 0 && p0_ack) || (port == 1 && p1_ack)) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("ack_timeout", 0, 1);
    endtask

    task automatic access(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask);
        @(negedge clk);
        push(port, we, addr, wdata, mask);
        drive(port, 1'b1, we, addr, wdata, mask);
        req_cyc = cyc;
        wait_ack(port);
        drive(port, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flag"}, mem_rw_flag, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_acks"}, {p0_ack, p1_ack}, 0);
        check({tag, "_rdata"}, {p0_rdata, p1_rdata}, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata_mask"}, {mem_wdata, mem_mask}, 0);
    endtask

    // Monitor: protocol checks at issue, hold checks during WAIT, scoreboard pop at ack.
    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                issue_seen = 0;
                flag_prev  = 2'b00;
            end else begin
                if (mem_rw_flag != 2'b00) begin
                    check("issue_pending", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        check("rw_flag", mem_rw_flag, {~sb[0].we, sb[0].we});
                        check("issue_addr", mem_addr, sb[0].addr);
                    end
                    check("flag_one_cycle", flag_prev, 0);
                    check("busy_issue", busy, 1);
                    if (issue_seen) begin
                        last_gap = cyc - issue_cyc;
                        check("issue_gap_min", last_gap >= 5, 1);
                    end
                    issue_cyc  = cyc;
                    issue_seen = 1;
                end else if (busy && sb.size() > 0) begin
                    check("hold_addr", mem_addr, sb[0].addr);
                    if (sb[0].we) check("hold_wdata_mask", {mem_wdata, mem_mask}, {sb[0].wdata, sb[0].mask});
                end
                if (p0_ack || p1_ack) begin
                    check("ack_exclusive", p0_ack & p1_ack, 0);
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("ack_port", p1_ack ? 1 : 0, e.port);
                        check("ack_rdata", (e.port == 1) ? p1_rdata : p0_rdata, e.rdata);
                        check("other_rdata", (e.port == 1) ? p0_rdata : p1_rdata, 0);
                        check("ack_latency", cyc - issue_cyc, 3);
                        last_rdata = (e.port == 1) ? p1_rdata : p0_rdata;
                    end
                end
                flag_prev = mem_rw_flag;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acks;
        int first_issue;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        init_ref();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Read of a preloaded word, request-to-issue latency of one cycle.
        access(0, 1'b0, 32'h10, '0, '0);
        check("t1_req_to_issue", issue_cyc - req_cyc, 1);
        check("t1_rdata", last_rdata, 32'hDEAD_BEEF);

        // Partial write then read-back merges only the low half.
        access(1, 1'b1, 32'h8, 32'h1122_3344, 4'b0011);
        access(0, 1'b0, 32'h8, '0, '0);
        check("t2_low_half", last_rdata[15:0], 16'h3344);
        check("t2_high_half", last_rdata[31:16], 16'hAABB);

        // Back-to-back reads with req held through the ack cycle.
        @(negedge clk);
        push(0, 1'b0, 32'h14, '0, '0);
        drive(0, 1'b1, 1'b0, 32'h14, '0, '0);
        wait_ack(0);
        first_issue = issue_cyc;
        push(0, 1'b0, 32'h18, '0, '0);
        drive(0, 1'b1, 1'b0, 32'h18, '0, '0);
        @(negedge clk);
        check("b2b_no_dup_busy", busy, 0);
        wait_ack(0);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        check("b2b_gap", issue_cyc - first_issue, 5);

        // Reset during WAIT abandons the access.
        @(negedge clk);
        push(0, 1'b0, 32'h10, '0, '0);
        drive(0, 1'b1, 1'b0, 32'h10, '0, '0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy && mem_rw_flag == 2'b00) break;
        end
        check("rst_in_wait", busy && mem_rw_flag == 2'b00, 1);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        check_all_zero("mid_rst");
        sb.delete();
        init_ref();
        rst = 1'b0;
        repeat (6) @(negedge clk);
        access(0, 1'b0, 32'h10, '0, '0);
        check("post_rst_rdata", last_rdata, 32'hDEAD_BEEF);

        // Both ports held: arbitration order from a fresh pointer.
        rst = 1'b1;
        init_ref();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
`ifdef DATA_MEM_ARB_RR_EN
            if (k % 2 == 0) push(1, 1'b0, 32'h24, '0, '0);
            else            push(0, 1'b0, 32'h20, '0, '0);
`else
            push(1, 1'b0, 32'h24, '0, '0);
`endif
        end
        drive(0, 1'b1, 1'b0, 32'h20, '0, '0);
        drive(1, 1'b1, 1'b0, 32'h24, '0, '0);
        acks = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) acks++;
            if (acks == 4) break;
        end
        check("prio_ack_count", acks, 4);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
`ifdef DATA_MEM_ARB_RR_EN
        drive(0, 1'b0, 1'b0, '0, '0, '0);
`else
        push(0, 1'b0, 32'h20, '0, '0);
        wait_ack(0);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
`endif
        repeat (8) @(negedge clk);
        check("final_idle", busy, 0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
